// File: rtl/conv_enc_tx.sv
// Rate-1/2 K=3 (7,5 octal) convolutional encoder with frame tail and one-deep output buffer.
// Optional CONV_ENC_ERR_INJ_EN adds err_mask[1:0], XORed into every loaded symbol.
module conv_enc_tx #(
  parameter int FRAME_LEN = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] sym_out,
  output logic       sym_tail,
  output logic       frame_done
`ifdef CONV_ENC_ERR_INJ_EN
  ,
  input  logic [1:0] err_mask
`endif
);

  localparam int CW = (FRAME_LEN < 2) ? 1 : $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {IDLE, DATA, TAIL, FLUSH} state_t;

  state_t        state_q, state_d;
  logic [1:0]    enc_q, enc_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic          tail_cnt_q, tail_cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [1:0]    sym_q, sym_d;
  logic          tail_q, tail_d;
  logic          done_q, done_d;

  logic       slot_free;
  logic       accept;
  logic       u;
  logic [1:0] code;
  logic [1:0] mask;

`ifdef CONV_ENC_ERR_INJ_EN
  assign mask = err_mask;
`else
  assign mask = 2'b00;
`endif

  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = ((state_q == IDLE) || (state_q == DATA)) && slot_free;
  assign accept    = in_valid && in_ready;
  // Tail symbols are encoded with u=0; outside an accept u is don't-care.
  assign u         = accept ? in_bit : 1'b0;
  assign code      = {u ^ enc_q[1] ^ enc_q[0], u ^ enc_q[0]};

  always_comb begin
    state_d     = state_q;
    enc_d       = enc_q;
    bit_cnt_d   = bit_cnt_q;
    tail_cnt_d  = tail_cnt_q;
    out_valid_d = out_valid_q;
    sym_d       = sym_q;
    tail_d      = tail_q;
    done_d      = 1'b0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE, DATA: begin
        if (accept) begin
          out_valid_d = 1'b1;
          sym_d       = code ^ mask;
          tail_d      = 1'b0;
          enc_d       = {u, enc_q[1]};
          if (bit_cnt_q == CW'(FRAME_LEN - 1)) begin
            bit_cnt_d = '0;
            state_d   = TAIL;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
            state_d   = DATA;
          end
        end
      end
      TAIL: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          sym_d       = code ^ mask;
          tail_d      = 1'b1;
          enc_d       = {1'b0, enc_q[1]};
          tail_cnt_d  = ~tail_cnt_q;
          if (tail_cnt_q) state_d = FLUSH;
        end
      end
      FLUSH: begin
        // Encoder is back at 00 here; wait for the last tail to leave.
        if (out_valid_q && out_ready) begin
          done_d     = 1'b1;
          tail_cnt_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      enc_q       <= 2'b00;
      bit_cnt_q   <= '0;
      tail_cnt_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sym_q       <= 2'b00;
      tail_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      enc_q       <= enc_d;
      bit_cnt_q   <= bit_cnt_d;
      tail_cnt_q  <= tail_cnt_d;
      out_valid_q <= out_valid_d;
      sym_q       <= sym_d;
      tail_q      <= tail_d;
      done_q      <= done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign sym_out    = sym_q;
  assign sym_tail   = tail_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_conv_enc_tx.sv
// Bench for conv_enc_tx: directed scenarios plus random traffic against a polynomial-level model.
module tb_conv_enc_tx;

  localparam int FL = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] sym_out;
  logic       sym_tail;
  logic       frame_done;
`ifdef CONV_ENC_ERR_INJ_EN
  logic [1:0] err_mask;
`endif

  conv_enc_tx #(.FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
    .out_valid(out_valid), .out_ready(out_ready), .sym_out(sym_out), .sym_tail(sym_tail),
    .frame_done(frame_done)
`ifdef CONV_ENC_ERR_INJ_EN
    , .err_mask(err_mask)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sym;
    logic       tail;
    logic       last;
  } ent_t;

  int         total = 0;
  int         bad = 0;
  ent_t       q[$];
  logic [2:0] obs[$];
  int         st = 0;
  int         nb = 0;
  bit         busy = 0;
  bit         done_exp = 0;
  bit         hold_v = 0;
  logic [2:0] hold_sym;
  int         fd_cnt = 0;
  bit         acc;
  logic [2:0] exp1 [8];
  logic [2:0] exp2 [8];

  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Generator view: window {u,s1,s0}; c1 = parity(w & 7), c0 = parity(w & 5).
  task automatic enc(input logic ub, input logic tl, input logic last, input logic [1:0] m);
    int   w;
    ent_t e;
    w      = (int'(ub) << 2) | st;
    e.sym  = {^(w[2:0] & 3'b111), ^(w[2:0] & 3'b101)} ^ m;
    e.tail = tl;
    e.last = last;
    st     = w >> 1;
    q.push_back(e);
  endtask

  task automatic cycle();
    ent_t       e;
    logic [1:0] m;
    @(negedge clk);
    acc = 0;
    if (rst) begin
      q.delete(); st = 0; nb = 0; busy = 0; done_exp = 0; hold_v = 0;
    end else begin
      if (frame_done === 1'b1) fd_cnt++;
      chk("frame_done", frame_done, done_exp);
      done_exp = 0;
      chk("out_valid", out_valid, q.size() != 0);
      chk("in_ready", in_ready, !busy && ((q.size() == 0) || out_ready));
      if (hold_v) chk("hold", {sym_tail, sym_out}, hold_sym);
      hold_v   = out_valid && !out_ready;
      hold_sym = {sym_tail, sym_out};
      if (out_valid && out_ready && q.size() != 0) begin
        e = q.pop_front();
        chk("sym", {sym_tail, sym_out}, {e.tail, e.sym});
        obs.push_back({sym_tail, sym_out});
        if (e.last) begin done_exp = 1; busy = 0; end
      end
      if (in_valid && in_ready) begin
        acc = 1;
        m = 2'b00;
`ifdef CONV_ENC_ERR_INJ_EN
        m = err_mask;
`endif
        enc(in_bit, 1'b0, 1'b0, m);
        nb++;
        if (nb == FL) begin
          nb = 0; busy = 1;
          enc(1'b0, 1'b1, 1'b0, 2'b00);
          enc(1'b0, 1'b1, 1'b1, 2'b00);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    int n;
    in_valid = 1'b1;
    in_bit   = b;
    n = 0;
    do begin cycle(); n++; end while (!acc && n < 50);
    if (!acc) begin total++; bad++; $error("FAIL accept_timeout observed=0 expected=1"); end
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    int f0;
    f0 = fd_cnt;
    n = 0;
    while (fd_cnt == f0 && n < 50) begin cycle(); n++; end
    if (fd_cnt == f0) begin total++; bad++; $error("FAIL done_timeout observed=0 expected=1"); end
  endtask

  task automatic cmp_obs(input string tag, input logic [2:0] ex [8]);
    chk({tag, "_len"}, 8'(obs.size()), 8'd8);
    for (int i = 0; i < 8 && i < obs.size(); i++) chk(tag, obs[i], ex[i]);
  endtask

  initial begin
    logic [5:0] bits;
    int         f0;
    exp1 = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b011, 3'b100, 3'b100};
    exp2 = '{3'b011, 3'b001, 3'b010, 3'b010, 3'b010, 3'b010, 3'b101, 3'b111};
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b1;
`ifdef CONV_ENC_ERR_INJ_EN
    err_mask = 2'b00;
`endif
    cycle(); cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sym_out", sym_out, 2'b00);
    chk("rst_sym_tail", sym_tail, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Scenario 1: 1,0,1,1,0,0
    obs.delete(); f0 = fd_cnt;
    bits = 6'b001101;
    for (int i = 0; i < FL; i++) send_bit(bits[i]);
    wait_done();
    cycle(); cycle();
    cmp_obs("s1", exp1);
    chk("s1_done_once", 8'(fd_cnt - f0), 8'd1);

    // Scenario 2: all ones
    obs.delete();
    for (int i = 0; i < FL; i++) send_bit(1'b1);
    wait_done();
    cmp_obs("s2", exp2);

    // Scenario 3: stall after second symbol
    obs.delete();
    send_bit(1'b1);
    send_bit(1'b0);
    out_ready = 1'b0; in_valid = 1'b1; in_bit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_sym", sym_out, 2'b10);
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    wait_done();
    cmp_obs("s3", exp1);

    // Scenario 4: continuous in_valid across frame boundaries
    in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      in_bit = 1'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) cycle();
    if (q.size() != 0) wait_done();

    // Scenario 5: reset mid-frame then clean frame
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_sym", sym_out, 2'b00);
    chk("mid_rst_done", frame_done, 1'b0);
    @(posedge clk); #1;
    obs.delete();
    for (int i = 0; i < FL; i++) send_bit(bits[i]);
    wait_done();
    cmp_obs("s5", exp1);

`ifdef CONV_ENC_ERR_INJ_EN
    // Scenario 6: error mask on the first symbol only
    obs.delete();
    err_mask = 2'b01;
    send_bit(bits[0]);
    err_mask = 2'b00;
    for (int i = 1; i < FL; i++) send_bit(bits[i]);
    wait_done();
    chk("err_first", obs[0], 3'b010);
    for (int i = 1; i < 8 && i < obs.size(); i++) chk("err_rest", obs[i], exp1[i]);
`endif

    // Random traffic with backpressure
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_bit    = 1'($urandom);
      out_ready = ($urandom % 3) != 0;
      if (i % 200 == 150) rst = 1'b1;
      cycle();
      rst = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
